// File: rtl/div.sv
// Iterative radix-2 32-bit divider for DIV/DIVU. It produces one quotient bit per cycle
// and returns {remainder, quotient}, which is held while start_in stays high.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_in,
    input  logic [31:0] opdata1_in,
    input  logic [31:0] opdata2_in,
    input  logic        start_in,
    input  logic        annul_in,
    output logic [63:0] result_out,
    output logic        ready_out
);

    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 6;
    localparam logic [1:0]  FREE   = 2'd0;
    localparam logic [1:0]  BYZERO = 2'd1;
    localparam logic [1:0]  ON     = 2'd2;
    localparam logic [1:0]  END    = 2'd3;

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  r, r_n, q, q_n, d, d_n;
    logic          sq, sq_n, sr, sr_n;
    logic [63:0]   result_n;
    logic          ready_n;
    logic [W:0]    diff;
    logic [W-1:0]  r_iter, q_iter;
    logic          neg1, neg2;

    // Restoring-division step: subtract only when the trial difference stays non-negative.
    always_comb begin
        diff   = {r, q[W-1]} - {1'b0, d};
        r_iter = diff[W] ? {r[W-2:0], q[W-1]} : diff[W-1:0];
        q_iter = {q[W-2:0], ~diff[W]};
    end

    // Next-state and datapath update.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        r_n      = r;
        q_n      = q;
        d_n      = d;
        sq_n     = sq;
        sr_n     = sr;
        result_n = result_out;
        ready_n  = ready_out;
        neg1     = signed_div_in & opdata1_in[W-1];
        neg2     = signed_div_in & opdata2_in[W-1];

        if (annul_in && state != END) begin
            state_n  = FREE;
            cnt_n    = '0;
            ready_n  = 1'b0;
            result_n = '0;
        end else begin
            case (state)
                FREE: begin
                    if (start_in) begin
                        q_n   = neg1 ? W'(~opdata1_in + W'(1)) : opdata1_in;
                        d_n   = neg2 ? W'(~opdata2_in + W'(1)) : opdata2_in;
                        sq_n  = neg1 ^ neg2;
                        sr_n  = neg1;
                        cnt_n = '0;
                        r_n   = '0;
                        state_n = (opdata2_in == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    result_n = '0;
                    ready_n  = 1'b1;
                    state_n  = END;
                end
                ON: begin
                    r_n   = r_iter;
                    q_n   = q_iter;
                    cnt_n = CW'(cnt + CW'(1));
                    if (cnt == CW'(31)) begin
                        result_n = {sr ? W'(W'(0) - r_iter) : r_iter,
                                    sq ? W'(W'(0) - q_iter) : q_iter};
                        ready_n  = 1'b1;
                        state_n  = END;
                    end
                end
                default: begin
                    if (!start_in) begin
                        state_n  = FREE;
                        ready_n  = 1'b0;
                        result_n = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FREE;
            cnt        <= '0;
            r          <= '0;
            q          <= '0;
            d          <= '0;
            sq         <= 1'b0;
            sr         <= 1'b0;
            result_out <= '0;
            ready_out  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            r          <= r_n;
            q          <= q_n;
            d          <= d_n;
            sq         <= sq_n;
            sr         <= sr_n;
            result_out <= result_n;
            ready_out  <= ready_n;
        end
    end

endmodule

// File: doc/div.md
# div

Iterative 32-bit radix-2 divider that sequences the shared divide datapath on behalf of the execute stage. It accepts a DIV or DIVU request through a start/ready handshake and computes one quotient bit per cycle. It returns `{remainder, quotient}` for the HI/LO write, and discards in-flight work on annul. While the divide is in progress, execute holds `start_in` high and asserts its stall request.

## Interface
- No parameters. Data width is fixed at 32 bits; the result is 64 bits.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high (`RstEnable` = 1'b1).
- signed_div_in  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- opdata1_in  in  32  dividend; sampled at start.
- opdata2_in  in  32  divisor; sampled at start.
- start_in  in  1  `DivStart` (1) requests or holds a divide; `DivStop` (0) releases the result.
- annul_in  in  1  cancel request, e.g. on flush.
- result_out  out  64  `{remainder[31:0], quotient[31:0]}`; `[63:32]` goes to HI and `[31:0]` to LO.
- ready_out  out  1  `DivResultReady` (1) while result_out is valid.

## Operation
- States:
  - FREE (idle).
  - BYZERO (divisor = 0).
  - ON (iterating).
  - END (result held).
- Registers:
  - state; cnt[5:0].
  - R[31:0] partial remainder; Q[31:0] dividend/quotient shift register.
  - D[31:0] divisor magnitude.
  - sq (negate quotient); sr (negate remainder).
- FREE:
  - If start_in=1 and annul_in=0 and opdata2_in=0 → BYZERO.
  - If start_in=1 and annul_in=0 and opdata2_in≠0 → ON with cnt=0 and R=0.
  - Operand latching:
    - Q = |opdata1_in| if signed and opdata1_in[31]=1, else opdata1_in.
    - D = |opdata2_in| under the same rule.
    - |x| = ~x+1, truncated to 32 bits, so 0x80000000 maps to itself.
    - sq = signed & (op1[31]^op2[31]); sr = signed & op1[31].
  - Otherwise stay in FREE.
- ON, one iteration per cycle:
  - t = {R, Q[31]} − {1'b0, D}, computed as a 33-bit subtraction.
  - If t[32]=1 (negative): R = {R[30:0], Q[31]}, Q = {Q[30:0], 0}.
  - Else: R = t[31:0], Q = {Q[30:0], 1}.
  - cnt increments by 1.
  - The cycle with cnt=31 performs the final iteration. It also loads:
    - result_out = {sr ? −R' : R', sq ? −Q' : Q'}, using the post-iteration values R' and Q'.
    - state = END.
- BYZERO: load result_out = 0 and go to END.
- END:
  - ready_out = 1 and result_out is held.
  - start_in=1 → stay in END.
  - start_in=0 → FREE, with ready_out=0 and result_out=0.
- annul_in=1 in FREE, BYZERO or ON:
  - Next state is FREE, cnt=0, ready_out=0, result_out=0.
  - Annul takes priority over start and over completion.
  - annul_in is ignored in END, where release happens only via start_in.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This wraps silently and raises no trap.
- Remainder sign follows the dividend; quotient truncates toward zero.

## Timing
- Reset values: state=FREE, cnt=0, R=Q=D=0, sq=sr=0, result_out=0, ready_out=0.
- Reset dominates every other input, in any state.
- All outputs are registered, with no combinational path from inputs to outputs.
- Let T be the cycle in which start_in=1 is sampled in FREE.
- Nonzero divisor:
  - ON occupies cycles T+1..T+32.
  - ready_out=1 from cycle T+33.
  - Latency is 33 cycles.
- Zero divisor:
  - BYZERO in cycle T+1.
  - ready_out=1 from cycle T+2.
- ready_out and result_out stay stable every cycle start_in remains 1 in END. Execute samples the result in the first ready cycle and drops start_in that same cycle.
- Back-to-back use: start_in=0 for one cycle in END returns the block to FREE. A new start is accepted one cycle after that (no start sampling in END).
- Operand changes after T do not affect the result.
- Annul in cycle A during ON: state=FREE in A+1, and no ready pulse is produced.

## Test plan
- Unsigned divide: start at T with opdata1=100, opdata2=7, signed=0 → ready_out rises at T+33 with result_out=0x00000002_0000000E.
- Signed divide: −7 / 2 (0xFFFFFFF9, 0x00000002, signed=1) → quotient 0xFFFFFFFD and remainder 0xFFFFFFFF. Also 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: 5 / 0 → ready_out=1 at T+2, result_out=0. Dropping start_in → ready_out=0 the next cycle.
- Annul: pulse annul_in at T+10 → ready_out never asserts and state is FREE at T+11. A new 100/7 started at T+11 completes at T+44 with the correct result.
- Overflow and hold: 0x80000000 / 0xFFFFFFFF signed → result 0x00000000_80000000. Holding start_in high for 5 cycles in END keeps result and ready_out constant.
- Reset mid-divide: assert rst at T+16 → next cycle ready_out=0 and result_out=0. A subsequent 0xFFFFFFFF / 0x10 unsigned divide gives 0x0000000F_0FFFFFFF.
